alu_sequencer: RTL and testbench

- Operation controller in front of the 32-bit ALU datapath.
- Accepts one operation at a time: opcode plus X/Y operands, using a start/ready handshake.
- Single-cycle ops (add, sub, shifts, rotates, and, or, neg, not) are sequenced through the external ALU.
- Multiply (radix-2 Booth) and divide (restoring, signed) run iteratively inside this block.
- Results land in a 64-bit HI:LO pair with a one-cycle done pulse.

---
 rtl/alu_sequencer.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// ============================================================================
//  Module      : alu_sequencer
//  Description : Operation controller in front of a 32-bit ALU datapath.
//                Accepts one operation at a time (start/ready handshake).
//                Single-cycle ops are sequenced through the external ALU.
//                Multiply (radix-2 Booth) and signed divide (restoring)
//                run iteratively inside this block. The result lands in a
//                HI:LO register pair, flagged by a one-cycle done pulse.
//  Ports       : clk, clr_n (sync active-low reset)
//                start/ready/busy/done  - handshake and status
//                op[11:0], x_in, y_in   - one-hot opcode and operands
//                result_hi, result_lo   - 2*BITS result
//                div_zero, op_err       - sticky flags, cleared on accept
//                alu_ctrl/alu_x/alu_y   - drive to the external ALU
//                alu_result             - result from the external ALU
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_sequencer #(
  parameter int BITS  = 32,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              start,
  input  logic [11:0]       op,
  input  logic [BITS-1:0]   x_in,
  input  logic [BITS-1:0]   y_in,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [BITS-1:0]   result_hi,
  output logic [BITS-1:0]   result_lo,
  output logic              div_zero,
  output logic              op_err,
  output logic [11:0]       alu_ctrl,
  output logic [BITS-1:0]   alu_x,
  output logic [BITS-1:0]   alu_y,
  input  logic [2*BITS-1:0] alu_result
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_MUL  = 3'd2,
    S_DIV  = 3'd3,
    S_FIX  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam int OP_MUL = 2;
  localparam int OP_DIV = 3;

  state_t            state;
  state_t            state_nx;

  logic [11:0]       op_reg;
  logic [BITS-1:0]   x_reg;
  logic [BITS-1:0]   y_reg;
  logic [BITS:0]     acc;       // Booth accumulator A / division remainder R
  logic [BITS-1:0]   q;         // Booth multiplier Q / division quotient
  logic              qm1;       // Booth q-1 bit
  logic [CNT_W-1:0]  cnt;
  logic [BITS-1:0]   hi_reg;
  logic [BITS-1:0]   lo_reg;
  logic              dz_reg;
  logic              oe_reg;

  // --------------------------------------------------------------------------
  // Decode of the incoming request
  // --------------------------------------------------------------------------
  logic              op_onehot;
  logic              op_div_zero;
  logic [BITS-1:0]   x_in_mag;
  logic              last_iter;

  // A value is one-hot when it is non-zero and clearing its lowest set bit
  // leaves nothing behind.
  assign op_onehot   = (op != 12'd0) && ((op & (op - 12'd1)) == 12'd0);
  assign op_div_zero = op[OP_DIV] && (y_in == '0);
  assign x_in_mag    = x_in[BITS-1] ? (~x_in + 1'b1) : x_in;
  assign last_iter   = (cnt == CNT_W'(BITS-1));

  // --------------------------------------------------------------------------
  // Booth multiply step
  // --------------------------------------------------------------------------
  logic [BITS:0]     m_ext;
  logic [BITS:0]     booth_sum;
  logic [BITS:0]     mul_acc_nx;
  logic [BITS-1:0]   mul_q_nx;

  // Multiplicand is sign-extended into the extra accumulator bit so that
  // A - M stays exact when M = -2^(BITS-1).
  assign m_ext = {y_reg[BITS-1], y_reg};

  always_comb begin
    booth_sum = acc;
    case ({q[0], qm1})
      2'b01:   booth_sum = acc + m_ext;
      2'b10:   booth_sum = acc - m_ext;
      default: booth_sum = acc;
    endcase
  end

  // Arithmetic right shift of {A, Q, q-1}.
  assign mul_acc_nx = {booth_sum[BITS], booth_sum[BITS:1]};
  assign mul_q_nx   = {booth_sum[0], q[BITS-1:1]};

  // --------------------------------------------------------------------------
  // Restoring divide step on magnitudes
  // --------------------------------------------------------------------------
  logic [BITS-1:0]   y_mag;
  logic [BITS:0]     rem_sh;
  logic [BITS:0]     trial;
  logic [BITS-1:0]   quo_fix;
  logic [BITS-1:0]   rem_fix;

  // |-2^(BITS-1)| reads back correctly as an unsigned BITS-wide magnitude.
  assign y_mag  = y_reg[BITS-1] ? (~y_reg + 1'b1) : y_reg;
  // The remainder is always below |Y| <= 2^(BITS-1), so its low BITS bits
  // carry the whole value before the shift.
  assign rem_sh = {acc[BITS-1:0], q[BITS-1]};
  assign trial  = rem_sh - {1'b0, y_mag};

  // Truncating division: quotient sign from sign(X)^sign(Y), remainder
  // follows the dividend.
  assign quo_fix = (x_reg[BITS-1] ^ y_reg[BITS-1]) ? (~q + 1'b1) : q;
  assign rem_fix = x_reg[BITS-1] ? (~acc[BITS-1:0] + 1'b1) : acc[BITS-1:0];

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    alu_ctrl = 12'd0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (start) begin
          if (!op_onehot || op_div_zero) begin
            state_nx = S_DONE;
          end else if (op[OP_MUL]) begin
            state_nx = S_MUL;
          end else if (op[OP_DIV]) begin
            state_nx = S_DIV;
          end else begin
            state_nx = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        alu_ctrl = op_reg;
        state_nx = S_DONE;
      end
      S_MUL: begin
        if (last_iter) begin
          state_nx = S_DONE;
        end
      end
      S_DIV: begin
        if (last_iter) begin
          state_nx = S_FIX;
        end
      end
      S_FIX: begin
        state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      op_reg <= 12'd0;
      x_reg  <= '0;
      y_reg  <= '0;
      acc    <= '0;
      q      <= '0;
      qm1    <= 1'b0;
      cnt    <= '0;
      hi_reg <= '0;
      lo_reg <= '0;
      dz_reg <= 1'b0;
      oe_reg <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_reg <= op;
            x_reg  <= x_in;
            y_reg  <= y_in;
            dz_reg <= 1'b0;
            oe_reg <= 1'b0;
            acc    <= '0;
            qm1    <= 1'b0;
            cnt    <= '0;
            if (!op_onehot) begin
              oe_reg <= 1'b1;
              hi_reg <= '0;
              lo_reg <= '0;
            end else if (op_div_zero) begin
              dz_reg <= 1'b1;
              hi_reg <= x_in;
              lo_reg <= '1;
            end else if (op[OP_MUL]) begin
              q <= x_in;
            end else if (op[OP_DIV]) begin
              q <= x_in_mag;
            end
          end
        end
        S_EXEC: begin
          hi_reg <= alu_result[2*BITS-1:BITS];
          lo_reg <= alu_result[BITS-1:0];
        end
        S_MUL: begin
          acc <= mul_acc_nx;
          q   <= mul_q_nx;
          qm1 <= q[0];
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            hi_reg <= mul_acc_nx[BITS-1:0];
            lo_reg <= mul_q_nx;
          end
        end
        S_DIV: begin
          if (!trial[BITS]) begin
            acc <= trial;
            q   <= {q[BITS-2:0], 1'b1};
          end else begin
            acc <= rem_sh;
            q   <= {q[BITS-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          lo_reg <= quo_fix;
          hi_reg <= rem_fix;
        end
        default: begin
        end
      endcase
    end
  end

  assign result_hi = hi_reg;
  assign result_lo = lo_reg;
  assign div_zero  = dz_reg;
  assign op_err    = oe_reg;
  assign alu_x     = x_reg;
  assign alu_y     = y_reg;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
//  Module      : tb_alu_sequencer
//  Description : Self-checking bench for alu_sequencer. Provides a stand-in
//                ALU and an arithmetic reference model of every operation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

  logic        clk;
  logic        clr_n;
  logic        start;
  logic [11:0] op;
  logic [31:0] x_in;
  logic [31:0] y_in;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result_hi;
  logic [31:0] result_lo;
  logic        div_zero;
  logic        op_err;
  logic [11:0] alu_ctrl;
  logic [31:0] alu_x;
  logic [31:0] alu_y;
  logic [63:0] alu_result;

  int n_assert = 0;
  int n_fail   = 0;

  alu_sequencer #(.BITS(32), .CNT_W(6)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .start      (start),
    .op         (op),
    .x_in       (x_in),
    .y_in       (y_in),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .result_hi  (result_hi),
    .result_lo  (result_lo),
    .div_zero   (div_zero),
    .op_err     (op_err),
    .alu_ctrl   (alu_ctrl),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_result (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU: adds/subs/neg are 64-bit signed; logic and shift ops put
  // ~Y in the upper half so HI routing is exercised too.
  function automatic logic [63:0] alu_fn(input logic [11:0] c,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint     la;
    longint     lb;
    logic [63:0] r;
    int         s;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    s  = int'(b[4:0]);
    case (c)
      12'h001: r = la + lb;
      12'h002: r = la - lb;
      12'h010: r = {~b, a >> s};
      12'h020: r = {~b, a << s};
      12'h040: r = {~b, (a >> s) | (a << ((32 - s) % 32))};
      12'h080: r = {~b, (a << s) | (a >> ((32 - s) % 32))};
      12'h100: r = {~b, a & b};
      12'h200: r = {~b, a | b};
      12'h400: r = -la;
      12'h800: r = {~b, ~a};
      default: r = 64'hDEAD_DEAD_DEAD_DEAD;
    endcase
    return r;
  endfunction

  // Junk on the bus whenever the ALU is not selected, so a capture outside
  // the execute cycle shows up in the result.
  always_comb begin
    alu_result = 64'hA5A5_5A5A_C3C3_3C3C;
    if (alu_ctrl != 12'd0) alu_result = alu_fn(alu_ctrl, alu_x, alu_y);
  end

  task automatic ref_model(input logic [11:0] o, input logic [31:0] x,
                           input logic [31:0] y, output logic [63:0] r,
                           output bit dz, output bit oe, output int lat);
    longint sx;
    longint sy;
    longint qq;
    longint rr;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    dz = 1'b0;
    oe = 1'b0;
    if ($countones(o) != 1) begin
      r = 64'd0; oe = 1'b1; lat = 1;
    end else if (o == 12'h008 && y == 32'd0) begin
      r = {x, 32'hFFFF_FFFF}; dz = 1'b1; lat = 1;
    end else if (o == 12'h004) begin
      r = sx * sy; lat = 33;
    end else if (o == 12'h008) begin
      qq = sx / sy;
      rr = sx % sy;
      r = {rr[31:0], qq[31:0]}; lat = 34;
    end else begin
      r = alu_fn(o, x, y); lat = 2;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " ready/busy/done"}, 64'({ready, busy, done}), 64'b100);
    check({tag, " hi:lo"}, {result_hi, result_lo}, 64'd0);
    check({tag, " flags"}, 64'({div_zero, op_err}), 64'd0);
    check({tag, " alu_ctrl"}, 64'(alu_ctrl), 64'd0);
    check({tag, " alu_x:alu_y"}, {alu_x, alu_y}, 64'd0);
  endtask

  // One complete transaction: accept, watch every cycle up to done, then
  // check latency, result, flags, operand latching and the hold after done.
  task automatic run_op(input string tag, input logic [11:0] o,
                        input logic [31:0] x, input logic [31:0] y);
    logic [63:0] exp_r;
    bit          exp_dz;
    bit          exp_oe;
    int          exp_lat;
    int          lat;
    bit          ctrl_ok;
    bit          is_exec;
    logic        d;
    ref_model(o, x, y, exp_r, exp_dz, exp_oe, exp_lat);
    is_exec = (exp_lat == 2);
    @(negedge clk);
    op = o; x_in = x; y_in = y; start = 1'b1;
    check({tag, " ready before accept"}, 64'(ready), 64'd1);
    lat = 0;
    ctrl_ok = 1'b1;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (alu_ctrl !== ((is_exec && c == 1) ? o : 12'd0)) ctrl_ok = 1'b0;
      d = done;
      if (c == 1) begin
        start = 1'b0; op = 12'($urandom); x_in = $urandom; y_in = $urandom;
      end
      if (d === 1'b1) begin
        lat = c;
        break;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " alu_ctrl"}, 64'(ctrl_ok), 64'd1);
    check({tag, " hi:lo"}, {result_hi, result_lo}, exp_r);
    check({tag, " div_zero/op_err"}, 64'({div_zero, op_err}), 64'({exp_dz, exp_oe}));
    check({tag, " ready/busy in done"}, 64'({ready, busy}), 64'b01);
    check({tag, " alu_x:alu_y"}, {alu_x, alu_y}, {x, y});
    @(negedge clk);
    check({tag, " done/ready after"}, 64'({done, ready}), 64'b01);
    check({tag, " hi:lo held"}, {result_hi, result_lo}, exp_r);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd0;
      3:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [11:0] ro;
    int          k;
    bit          seen;

    clr_n = 1'b0; start = 1'b0; op = 12'd0;
    x_in = $urandom; y_in = $urandom;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    clr_n = 1'b1;

    // Directed cases
    run_op("add 7+5",       12'h001, 32'd7, 32'd5);
    run_op("mul -3*7",      12'h004, 32'hFFFF_FFFD, 32'd7);
    run_op("mul min*min",   12'h004, 32'h8000_0000, 32'h8000_0000);
    run_op("div -17/5",     12'h008, 32'hFFFF_FFEF, 32'd5);
    run_op("div 17/-5",     12'h008, 32'd17, 32'hFFFF_FFFB);
    run_op("div 100/0",     12'h008, 32'd100, 32'd0);
    run_op("add clears dz", 12'h001, 32'd1, 32'd1);
    run_op("op 0x003",      12'h003, 32'd9, 32'd9);
    run_op("op 0x000",      12'h000, 32'd9, 32'd9);
    run_op("div min/-1",    12'h008, 32'h8000_0000, 32'hFFFF_FFFF);

    // Busy start ignored, reset abandons a multiply
    @(negedge clk);
    op = 12'h004; x_in = 32'd12345; y_in = 32'd678; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 5) begin
        check("busy ready", 64'(ready), 64'd0);
        op = 12'h001; start = 1'b1;
      end
      if (c == 6) check("busy pulse ignored", 64'({busy, done}), 64'b10);
      if (c == 10) clr_n = 1'b0;
    end
    @(negedge clk);
    check_reset_state("mid-op reset");
    clr_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    check("no done after reset", 64'(seen), 64'd0);
    run_op("sub 5-9", 12'h002, 32'd5, 32'd9);

    // Start held high: re-accept in the IDLE cycle after DONE
    @(negedge clk);
    op = 12'h001; x_in = 32'd1; y_in = 32'd2; start = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check("held start first done", 64'(seen), 64'd1);
    check("held start first result", {result_hi, result_lo}, 64'd3);
    x_in = 32'd10; y_in = 32'd20;
    @(negedge clk);
    check("held start idle", 64'({ready, busy}), 64'b10);
    @(negedge clk);
    check("held start re-accept", 64'(busy), 64'd1);
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check("held start second result", {result_hi, result_lo}, 64'd30);

    // Randomized operations against the reference model
    for (int i = 0; i < 48; i++) begin
      k = $urandom_range(0, 13);
      if (k < 12) ro = 12'd1 << k;
      else if (k == 12) ro = 12'h0C0 | 12'($urandom);
      else ro = 12'd0;
      run_op($sformatf("rand%0d op=%h", i, ro), ro, pick_operand(), pick_operand());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
